// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and load/store requests onto one single-port memory
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_mem_req, r_mem_we, r_own_d, r_err;
    logic [3:0]  r_mem_be, r_tcnt;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;
    logic [2:0]  r_size;
    logic [1:0]  r_off, r_starve;
    logic        w_grant_f, w_grant_d, w_d_bad, w_busy, w_timeout, w_sx;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data, w_shift, w_ld_data;

    // a starved fetch (two data grants in a row while it waited) overrides data
    assign w_grant_f = if_req && (r_starve == 2'd2 || !d_req);
    assign w_grant_d = d_req && !w_grant_f;
    assign w_d_bad   = (d_we ? (d_size[2] || d_size[1:0] == 2'b11)
                             : (d_size == 3'b011 || d_size[2:1] == 2'b11))
                     || (d_size[1:0] == 2'b01 && d_addr[0])
                     || (d_size[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
    assign w_busy    = (r_state == DATA) || (r_state == FETCH);
    assign w_timeout = w_busy && !mem_ack && (r_tcnt == 4'(TIMEOUT - 1));
    assign w_st_data = d_size[1] ? d_wdata : (d_size[0] ? {2{d_wdata[15:0]}} : {4{d_wdata[7:0]}});
    assign w_st_be   = d_size[1] ? 4'hF : ((d_size[0] ? 4'b0011 : 4'b0001) << d_addr[1:0]);
    assign w_shift   = mem_rdata >> {r_off, 3'b000};
    assign w_sx      = !r_size[2];
    assign w_ld_data = r_size[1] ? mem_rdata
                     : r_size[0] ? {{16{w_sx & w_shift[15]}}, w_shift[15:0]}
                     : {{24{w_sx & w_shift[7]}}, w_shift[7:0]};

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign d_ready   = (r_state == RESP) && r_own_d;
    assign if_ready  = (r_state == RESP) && !r_own_d;
    assign d_err     = d_ready && r_err;
    assign if_err    = if_ready && r_err;
    assign d_rdata   = r_rdata;
    assign if_rdata  = r_rdata;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: grant from IDLE, finish on ack or timeout, single-cycle response
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        w_next = w_grant_f ? FETCH : (w_grant_d ? (w_d_bad ? RESP : DATA) : IDLE);
            DATA, FETCH: w_next = (mem_ack || w_timeout) ? RESP : r_state;
            default:     w_next = IDLE;
        endcase
    end

    // latch the granted access, track starvation and timeout, capture the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_starve    <= 2'd0;
            r_tcnt      <= 4'd0;
            r_own_d     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_size      <= 3'd0;
            r_off       <= 2'd0;
        end else if (r_state == IDLE) begin
            r_tcnt <= 4'd0;
            if (w_grant_f) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_be   <= 4'hF;
                r_mem_addr <= if_addr & ADDR_MASK;
                r_own_d    <= 1'b0;
                r_err      <= 1'b0;
                r_starve   <= 2'd0;
            end else if (w_grant_d) begin
                r_own_d <= 1'b1;
                r_err   <= w_d_bad;
                r_rdata <= 32'h0;
                r_size  <= d_size;
                r_off   <= d_addr[1:0];
                if (if_req && r_starve != 2'd2) r_starve <= r_starve + 2'd1;
                if (!w_d_bad) begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= d_we;
                    r_mem_be    <= d_we ? w_st_be : 4'hF;
                    r_mem_addr  <= d_addr & ADDR_MASK;
                    r_mem_wdata <= w_st_data;
                end
            end
        end else if (w_busy) begin
            if (mem_ack) begin
                r_mem_req <= 1'b0;
                r_err     <= 1'b0;
                r_rdata   <= r_own_d ? w_ld_data : mem_rdata;
            end else if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_err     <= 1'b1;
                r_rdata   <= 32'h0;
            end else begin
                r_tcnt <= r_tcnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and randomized model check for mem_arbiter
module tb_mem_arbiter;
    localparam int TO = 3;

    logic        clk, rst_n;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_size;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, if_err, d_ready, d_err, mem_req, mem_we;
    logic [3:0]  mem_be;

    int          checks = 0;
    int          errors = 0;
    int          ack_wait = 0;
    int          hi_cnt = 0;
    bit          spur = 0;
    logic [31:0] mem_word = 32'h0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [2:0]  size;
        logic [31:0] word;
        logic        err;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endfunction

    // memory responder: acks after ack_wait extra cycles of mem_req; optional stray acks when idle
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req) begin
            mem_ack = (hi_cnt == ack_wait);
            hi_cnt++;
        end else begin
            mem_ack = spur && ($urandom_range(3) == 0);
            hi_cnt = 0;
        end
        mem_rdata = mem_ack ? mem_word : $urandom;
    endtask

    // reference for a data request, from the addressing rules directly
    function automatic void dmodel(input logic we, input logic [2:0] sz, input logic [31:0] a, wd, word,
                                   output bit err, output logic [3:0] be, output logic [31:0] wout, rout);
        int     nb  = 1 << sz[1:0];
        int     off = int'(a % 4);
        bit     legal;
        longint v;
        legal = we ? (sz <= 3'd2) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (a % nb) != 0;
        be    = we ? 4'(((1 << nb) - 1) << off) : 4'hF;
        wout  = nb == 1 ? 32'(wd[7:0]) * 32'h0101_0101 : nb == 2 ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        v     = longint'(word >> (8 * off)) % (longint'(1) << (8 * nb));
        if (sz < 3'd4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        rout  = err ? 32'h0 : 32'(v);
    endfunction

    // from an IDLE cycle with requests driven: follow one access to its ready pulse
    task automatic run_txn(input bit exp_d, input bit rq_err, input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic e_we, input logic [31:0] e_wdata, input bit chk_rd, input logic [31:0] e_rdata);
        int          k = 0;
        int          hi = 0;
        int          exp_k;
        bit          to, unstable = 0;
        logic [31:0] a, w;
        logic [3:0]  b;
        logic        we;
        to    = !rq_err && ack_wait >= TO;
        exp_k = rq_err ? 1 : (to ? TO + 1 : ack_wait + 2);
        do begin
            tick();
            k++;
            if (mem_req) begin
                if (hi == 0) begin
                    a = mem_addr; b = mem_be; w = mem_wdata; we = mem_we;
                end else if ({a, b, w, we} !== {mem_addr, mem_be, mem_wdata, mem_we}) unstable = 1;
                hi++;
            end
        end while (!(if_ready || d_ready) && k < 40);
        chk("latency", k, exp_k);
        chk("req_cycles", hi, exp_k - 1);
        chk("d_ready", d_ready, exp_d);
        chk("if_ready", if_ready, !exp_d);
        chk("err", exp_d ? d_err : if_err, rq_err || to);
        if (chk_rd || rq_err || to) chk("rdata", exp_d ? d_rdata : if_rdata, (rq_err || to) ? 32'h0 : e_rdata);
        if (!rq_err) begin
            chk("mem_addr", a, e_addr);
            chk("mem_be", b, e_be);
            chk("mem_we", we, e_we);
            if (e_we) chk("mem_wdata", w, e_wdata);
            chk("mem_stable", unstable, 0);
        end
    endtask

    task automatic to_idle();
        tick();
        chk("one_pulse", {if_ready, d_ready}, 0);
        chk("idle_req", mem_req, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; spur = 0;
        #1;
        chk("rst_mem", {mem_req, mem_we, mem_be}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        chk("rst_flags", {if_ready, d_ready, if_err, d_err}, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_d(input logic we, input logic [31:0] a, wd, input logic [2:0] sz);
        d_we = we; d_addr = a; d_wdata = wd; d_size = sz;
    endtask

    vec_t        vecs[14];
    bit          fp, dp, exp_d, e_err;
    logic [31:0] fa, e_wd, e_rd;
    logic [3:0]  e_be;
    int          ms;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        set_d(1'b0, 32'h0, 32'h0, 3'd0);
        vecs[0]  = '{1'b0, 32'h103, 32'h0,         3'd0, 32'h80FF_FF00, 1'b0, 32'h100, 4'hF, 32'h0,         32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 32'h022, 32'h1234_ABCD, 3'd1, 32'h0,         1'b0, 32'h020, 4'hC, 32'hABCD_ABCD, 32'h0};
        vecs[2]  = '{1'b0, 32'h006, 32'h0,         3'd2, 32'h0,         1'b1, 32'h0,   4'h0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 32'h101, 32'h0,         3'd4, 32'h1234_5678, 1'b0, 32'h100, 4'hF, 32'h0,         32'h56};
        vecs[4]  = '{1'b0, 32'h202, 32'h0,         3'd1, 32'h8001_7FFF, 1'b0, 32'h200, 4'hF, 32'h0,         32'hFFFF_8001};
        vecs[5]  = '{1'b0, 32'h202, 32'h0,         3'd5, 32'h8001_7FFF, 1'b0, 32'h200, 4'hF, 32'h0,         32'h8001};
        vecs[6]  = '{1'b0, 32'h304, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0, 32'h304, 4'hF, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 32'h403, 32'hA5,        3'd0, 32'h0,         1'b0, 32'h400, 4'h8, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b1, 32'h500, 32'hCAFE_F00D, 3'd2, 32'h0,         1'b0, 32'h500, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b0, 32'h600, 32'h0,         3'd3, 32'h0,         1'b1, 32'h0,   4'h0, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 32'h700, 32'h0,         3'd4, 32'h0,         1'b1, 32'h0,   4'h0, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 32'h801, 32'h0,         3'd1, 32'h0,         1'b1, 32'h0,   4'h0, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 32'h100, 32'h0,         3'd0, 32'h0000_007F, 1'b0, 32'h100, 4'hF, 32'h0,         32'h7F};
        vecs[13] = '{1'b0, 32'h102, 32'h0,         3'd0, 32'h00FF_0000, 1'b0, 32'h100, 4'hF, 32'h0,         32'hFFFF_FFFF};
        do_reset();

        for (int i = 0; i < 14; i++) begin
            set_d(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size);
            d_req = 1'b1; ack_wait = 0; mem_word = vecs[i].word;
            run_txn(1, vecs[i].err, vecs[i].e_addr, vecs[i].e_be, vecs[i].we, vecs[i].e_wdata, !vecs[i].we, vecs[i].e_rdata);
            d_req = 1'b0;
            to_idle();
        end

        if_addr = 32'h1237; if_req = 1'b1; ack_wait = TO + 2;
        run_txn(0, 0, 32'h1234, 4'hF, 1'b0, 32'h0, 1, 32'h0);
        if_req = 1'b0;
        to_idle();
        if_req = 1'b1; ack_wait = TO - 1; mem_word = 32'h5A5A_1234;
        run_txn(0, 0, 32'h1234, 4'hF, 1'b0, 32'h0, 1, 32'h5A5A_1234);
        if_req = 1'b0;
        to_idle();
        set_d(1'b0, 32'h20, 32'h0, 3'd2); d_req = 1'b1; ack_wait = TO;
        run_txn(1, 0, 32'h20, 4'hF, 1'b0, 32'h0, 1, 32'h0);
        d_req = 1'b0;
        to_idle();

        do_reset();
        if_addr = 32'h40; set_d(1'b0, 32'h10, 32'h0, 3'd2); if_req = 1'b1; d_req = 1'b1; ack_wait = 0;
        for (int i = 0; i < 6; i++) begin
            exp_d = (i % 3) != 2;
            mem_word = 32'h1111_0000 + 32'(i);
            run_txn(exp_d, 0, exp_d ? 32'h10 : 32'h40, 4'hF, 1'b0, 32'h0, 1, mem_word);
            to_idle();
        end
        if_req = 1'b0; d_req = 1'b0;
        to_idle();

        set_d(1'b0, 32'h104, 32'h0, 3'd2); d_req = 1'b1; ack_wait = 99;
        tick();
        tick();
        chk("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_addr", mem_addr, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_no_ready", {if_ready, d_ready}, 0);
        end
        rst_n = 1'b1; ack_wait = 0; mem_word = 32'hABCD_0123;
        run_txn(1, 0, 32'h104, 4'hF, 1'b0, 32'h0, 1, 32'hABCD_0123);
        d_req = 1'b0;
        to_idle();

        do_reset();
        ms = 0; fp = 0; dp = 0;
        for (int n = 0; n < 300; n++) begin
            if (!fp && (!dp || $urandom_range(1) == 0)) begin
                fp = 1; fa = $urandom;
            end
            if (!dp && $urandom_range(1) == 0) begin
                dp = 1;
                set_d(1'($urandom_range(1)), $urandom, $urandom, 3'($urandom_range(7)));
            end
            if_req = fp; d_req = dp; if_addr = fa;
            ack_wait = $urandom_range(TO + 1); mem_word = $urandom; spur = 1'($urandom_range(1));
            exp_d = dp && !(fp && ms == 2);
            if (exp_d) begin
                dmodel(d_we, d_size, d_addr, d_wdata, mem_word, e_err, e_be, e_wd, e_rd);
                run_txn(1, e_err, d_addr & 32'hFFFF_FFFC, e_be, d_we, e_wd, !d_we, e_rd);
                if (fp && ms < 2) ms++;
                dp = 0; d_req = 1'b0;
            end else begin
                run_txn(0, 0, fa & 32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0, 1, mem_word);
                ms = 0; fp = 0; if_req = 1'b0;
            end
            to_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
